// File: rtl/console_uart_tx.sv
// console_uart_tx
//   Buffers console byte writes in a small FIFO and sends them out as 8N1
//   UART frames (start bit, 8 data bits LSB first, stop bit).
//
//   Handshake: a write is offered by holding console_we high for one cycle
//   with the byte in console_wdata[7:0]. It is accepted on that clock edge
//   exactly when console_full is low. A write offered while console_full is
//   high is dropped and latches overflow. console_full is a registered-state
//   flag, so it never depends combinationally on console_we.
//
//   Parameters
//     XLEN          width of console_wdata (only [7:0] is sent)
//     CLKS_PER_BIT  clk cycles per serial bit, >= 2
//     FIFO_DEPTH    FIFO entries, power of two, >= 2
//
//   Ports
//     clk            system clock
//     reset          synchronous, active-high reset
//     console_we     console write strobe, one byte per asserted cycle
//     console_wdata  console data, bits above [7:0] ignored
//     console_full   FIFO holds FIFO_DEPTH bytes
//     overflow       sticky, set when a write was dropped; cleared by reset
//     busy           a frame is in progress or bytes are waiting
//     tx             registered serial line, idles high
//
//   Optional feature macro: CONSOLE_CRLF_EN
//     When defined, a 0x0A at the FIFO head is preceded on the line by 0x0D.
//     The CR frame is sent without popping; the following frame pops the LF.
module console_uart_tx #(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            console_full,
    output logic            overflow,
    output logic            busy,
    output logic            tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    logic unused_wdata_hi;
    assign unused_wdata_hi = &{1'b0, console_wdata[XLEN-1:8]};

    assign fifo_empty   = (count == '0);
    assign console_full = (count == FULL_COUNT);
    // A write while full is lost even if the FSM pops on the same edge.
    assign push         = console_we && !console_full;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= console_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (console_we && console_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Transmit FSM
    // ---------------------------------------------------------------
    state_t           state,   state_next;
    logic [CNT_W-1:0] cnt,     cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift,   shift_next;
    logic             tx_next;
    logic             load;
`ifdef CONSOLE_CRLF_EN
    logic             cr_pending, cr_next;
`endif

    assign busy = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
`ifdef CONSOLE_CRLF_EN
            cr_pending <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shift      <= shift_next;
            tx         <= tx_next;
`ifdef CONSOLE_CRLF_EN
            cr_pending <= cr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        load       = 1'b0;
        pop        = 1'b0;
`ifdef CONSOLE_CRLF_EN
        cr_next    = cr_pending;
`endif

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (cnt == '0) begin
                    // Data bits leave from shift[0]; the register shifts right
                    // each time a bit is put on the line.
                    state_next = DATA;
                    cnt_next   = BIT_RELOAD;
                    bit_next   = 3'd0;
                    tx_next    = shift[0];
                    shift_next = {1'b0, shift[7:1]};
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_next = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        tx_next    = shift[0];
                        shift_next = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (load) begin
            state_next = START;
            cnt_next   = BIT_RELOAD;
            bit_next   = 3'd0;
            tx_next    = 1'b0;
`ifdef CONSOLE_CRLF_EN
            // An LF at the head first produces a CR frame and stays queued.
            if ((head == 8'h0A) && !cr_pending) begin
                shift_next = 8'h0D;
                cr_next    = 1'b1;
            end else begin
                shift_next = head;
                pop        = 1'b1;
                cr_next    = 1'b0;
            end
`else
            shift_next = head;
            pop        = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
`timescale 1ns/1ps
module tb_console_uart_tx;

    localparam int XLEN  = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            console_we;
    logic [XLEN-1:0] console_wdata;
    logic            console_full;
    logic            overflow;
    logic            busy;
    logic            tx;

    console_uart_tx #(
        .XLEN(XLEN),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .console_we(console_we),
        .console_wdata(console_wdata),
        .console_full(console_full),
        .overflow(overflow),
        .busy(busy),
        .tx(tx)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [31:0] d);
        console_we    = 1'b1;
        console_wdata = d;
        @(posedge clk);
        #1;
        console_we = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        console_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        start_q.delete();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        check("idle_timeout_busy", busy, 0);
    endtask

    // ---------------- line receiver (reference) ----------------
    // Independent 8N1 receiver: finds the falling edge of a start bit and
    // samples every bit near its centre, then checks against exp_q.
    initial begin : receiver
        int         pos;
        bit         active;
        logic [7:0] b;
        pos    = 0;
        active = 0;
        b      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1;
                    pos    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                pos++;
                if (pos == 2) begin
                    check("rx_start_bit", tx, 0);
                end else if (pos >= 6 && pos <= 34 && ((pos - 6) % 4) == 0) begin
                    b[(pos - 6) / 4] = tx;
                end else if (pos == 38) begin
                    check("rx_stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_unexpected_frame: got %0h expected none (cycle %0d)", b, cyc);
                    end else begin
                        check("rx_byte", b, exp_q.pop_front());
                    end
                    active = 0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] wdata;
        logic [9:0]  frame;   // line level per bit slot, slot 0 = start bit in [0]
    } vec_t;

    vec_t vecs[6];

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0]  got;
        logic [31:0] d;
        int          len;
        int          n;

        vecs[0] = '{32'hFFFFFF41, 10'b1010000010};
        vecs[1] = '{32'h00000000, 10'b1000000000};
        vecs[2] = '{32'h000000FF, 10'b1111111110};
        vecs[3] = '{32'hDEAD00A5, 10'b1101001010};
        vecs[4] = '{32'h12345680, 10'b1100000000};
        vecs[5] = '{32'h0000003C, 10'b1001111000};

        console_we    = 1'b0;
        console_wdata = '0;
        do_reset();

        // Reset values
        check("reset_tx", tx, 1);
        check("reset_full", console_full, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);

        // Single frames, slot by slot, from the table
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].wdata[7:0]);
            write(vecs[v].wdata);
            for (int s = 0; s < 10; s++) begin
                for (int c = 0; c < 4; c++) begin
                    step(1);
                    got[c] = tx;
                end
                check($sformatf("vec%0d_slot%0d", v, s), got, {4{vecs[v].frame[s]}});
            end
            step(1);
            check($sformatf("vec%0d_idle_busy", v), busy, 0);
            check($sformatf("vec%0d_idle_tx", v), tx, 1);
        end

        // Back-to-back frames
        do_reset();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h21);
        write(32'h48);
        write(32'h69);
        write(32'h21);
        wait_idle(400);
        step(2);
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", start_q[1] - start_q[0], 10 * CPB);
            check("b2b_gap2", start_q[2] - start_q[1], 10 * CPB);
        end

        // Overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write(32'h30 + i);
            if (i < 5) exp_q.push_back(8'(8'h30 + i));
            if (i == 3) check("ovf_full_after_4th", console_full, 0);
            if (i == 4) check("ovf_full_after_5th", console_full, 1);
            if (i == 4) check("ovf_flag_before_drop", overflow, 0);
            if (i == 5) check("ovf_flag_after_drop", overflow, 1);
        end
        wait_idle(600);
        step(2);
        check("ovf_sticky", overflow, 1);
        check("ovf_all_sent", exp_q.size(), 0);
        do_reset();
        check("ovf_cleared_by_reset", overflow, 0);

        // Reset in the middle of data bit 3 of 0x55, two bytes queued
        write(32'h55);
        write(32'hAA);
        write(32'h33);
        step(16);
        check("rst_mid_tx_bit3", tx, 0);
        exp_q.delete();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_mid_tx_high", tx, 1);
        check("rst_mid_busy", busy, 0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (tx !== 1'b1) n++;
        end
        check("rst_mid_no_frames", n, 0);

        // LF handling
        do_reset();
`ifdef CONSOLE_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        write(32'h0A);
        n = 0;
        while (busy && n < 300) begin
            n++;
            step(1);
        end
`ifdef CONSOLE_CRLF_EN
        check("crlf_busy_cycles", n, 20 * CPB + 1);
        step(2);
        check("crlf_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("crlf_gap", start_q[1] - start_q[0], 10 * CPB);
`else
        check("lf_busy_cycles", n, 10 * CPB + 1);
        step(2);
        check("lf_frames", start_q.size(), 1);
`endif

        // Write while full on the edge where STOP ends
        do_reset();
        write(32'h60);
        for (int i = 1; i < 5; i++) write(32'h60 + i);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h60 + i));
        step(36);
        check("coll_full_before", console_full, 1);
        check("coll_ovf_before", overflow, 0);
        write(32'h7F);
        check("coll_full_after_pop", console_full, 0);
        check("coll_ovf_after", overflow, 1);
        write(32'h65);
        exp_q.push_back(8'h65);
        check("coll_full_refill", console_full, 1);
        wait_idle(800);
        step(2);
        check("coll_frames", start_q.size(), 6);
        if (start_q.size() >= 2) check("coll_gap", start_q[1] - start_q[0], 10 * CPB);

        // Randomized bursts against the receiver model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                d = $urandom();
                write(d);
`ifdef CONSOLE_CRLF_EN
                if (d[7:0] == 8'h0A) exp_q.push_back(8'h0D);
`endif
                exp_q.push_back(d[7:0]);
            end
            console_wdata = $urandom();
            wait_idle(1000);
            step($urandom_range(0, 5));
        end
        step(50);
        check("rand_no_overflow", overflow, 0);
        check("final_all_received", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
